// File: rtl/mac_operand_feeder.sv
// Operand feeder for the 4-bit MAC: buffers {i,j,last} pairs, clears/streams the MAC per vector
// and returns the captured 9-bit sum. Define MAC_FEEDER_OVF_EN to add the r_ovf shadow accumulator.
module mac_operand_feeder #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [3:0] s_i,
    input  logic [3:0] s_j,
    input  logic       s_last,
    output logic [3:0] mac_i,
    output logic [3:0] mac_j,
    output logic       mac_rst,
    input  logic [8:0] mac_f,
    output logic       r_valid,
    input  logic       r_ready,
    output logic [8:0] r_data,
    output logic       r_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0] i;
        logic [3:0] j;
        logic       last;
    } pair_t;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, CAPTURE, RESULT} state_t;

    pair_t        mem_q [DEPTH];
    pair_t        mem_d [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         full, empty, push, pop;
    pair_t        head;

    state_t       state_q, state_d;
    logic [3:0]   mac_i_q, mac_i_d, mac_j_q, mac_j_d;
    logic         mac_rst_q, mac_rst_d;
    logic         last_q, last_d;
    logic         r_valid_q, r_valid_d;
    logic [8:0]   r_data_q, r_data_d;

    // Extra pointer bit distinguishes full from empty.
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_q[AW-1:0]] = '{i: s_i, j: s_j, last: s_last};
        wr_d = wr_q + (AW+1)'(push);
        rd_d = rd_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d  = state_q;
        r_data_d = r_data_q;
        unique case (state_q)
            IDLE:    if (!empty || push) state_d = CLEAR;
            CLEAR:   state_d = STREAM;
            STREAM:  if (last_q) state_d = CAPTURE;
            CAPTURE: begin
                state_d  = RESULT;
                r_data_d = mac_f;
            end
            RESULT:  if (r_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: a pair popped now is on mac_i/mac_j next cycle.
        pop     = (state_d == STREAM) && !empty;
        mac_i_d = pop ? head.i : 4'd0;
        mac_j_d = pop ? head.j : 4'd0;
        last_d  = pop && head.last;

        mac_rst_d = (state_d == STREAM) || (state_d == CAPTURE) || (state_d == RESULT);
        r_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            state_q   <= IDLE;
            mac_i_q   <= '0;
            mac_j_q   <= '0;
            mac_rst_q <= 1'b0;
            last_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            state_q   <= state_d;
            mac_i_q   <= mac_i_d;
            mac_j_q   <= mac_j_d;
            mac_rst_q <= mac_rst_d;
            last_q    <= last_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
        end
    end

    assign mac_i   = mac_i_q;
    assign mac_j   = mac_j_q;
    assign mac_rst = mac_rst_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;

`ifdef MAC_FEEDER_OVF_EN
    logic [11:0] shadow_q, shadow_d;
    logic        r_ovf_q, r_ovf_d;

    always_comb begin
        shadow_d = shadow_q;
        r_ovf_d  = r_ovf_q;
        if (state_q == CLEAR)
            shadow_d = '0;
        else if (state_q == STREAM)
            shadow_d = shadow_q + 12'(mac_i_q) * 12'(mac_j_q);
        if (state_q == CAPTURE)
            r_ovf_d = (shadow_q > 12'd511);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            r_ovf_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            r_ovf_q  <= r_ovf_d;
        end
    end

    assign r_ovf = r_ovf_q;
`else
    assign r_ovf = 1'b0;
`endif

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Operand-side driver for the 4-bit MAC unit: accepts a stream of 4-bit operand pairs through a valid/ready interface and buffers them in a small FIFO. It clears the MAC accumulator at the start of each vector, then presents one pair per cycle to the MAC's operand ports. When the vector ends, it captures the MAC's 9-bit accumulated result and returns it on a valid/ready result port. It sits between the upstream data source and the MAC, and owns the MAC's operand and reset pins.

## Interface
- DEPTH, 8, operand FIFO depth in pairs; power of two, 2..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream pair valid.
- s_ready  out  1  FIFO can accept a pair; equals not-full.
- s_i  in  4  operand i.
- s_j  in  4  operand j.
- s_last  in  1  marks the final pair of a vector.
- mac_i  out  4  operand i to MAC.
- mac_j  out  4  operand j to MAC.
- mac_rst  out  1  MAC accumulator reset, active-low; clears the MAC sum at the clock edge while low.
- mac_f  in  9  MAC accumulated sum.
- r_valid  out  1  result valid.
- r_ready  in  1  downstream accepts result.
- r_data  out  9  captured vector sum.
- r_ovf  out  1  sum exceeded 511 (only with MAC_FEEDER_OVF_EN; otherwise tied 0).

## Operation
- FIFO stores {s_i, s_j, s_last}.
  - Push on s_valid && s_ready.
  - Not fall-through: a pair pushed in cycle k is poppable no earlier than cycle k+1.
  - When the FIFO is full, s_ready=0 even if a pop occurs in the same cycle.
- FSM states: IDLE, CLEAR, STREAM, CAPTURE, RESULT.
  - IDLE: mac_rst=0, mac_i=mac_j=0. Go to CLEAR when the FIFO is non-empty.
  - CLEAR: one cycle; mac_rst=0 so the MAC sum is 0 at the next edge. Go to STREAM.
  - STREAM: mac_rst=1.
    - FIFO non-empty: pop one pair and drive it on mac_i/mac_j this cycle.
    - FIFO empty (mid-vector underrun): drive mac_i=mac_j=0, which adds zero; stay in STREAM.
    - Popped pair has last=1: go to CAPTURE.
  - CAPTURE: mac_rst=1, mac_i=mac_j=0. Register r_data<=mac_f. Go to RESULT.
  - RESULT: r_valid=1; r_data held stable; mac_i=mac_j=0, mac_rst=1.
    - On r_valid && r_ready, go to IDLE; r_valid drops the next cycle.
    - r_valid must not drop before the handshake.
- Pushes continue in every state; the next vector may be buffered during STREAM/RESULT.
- Arithmetic: the MAC wraps modulo 512. r_data is the raw mac_f (9 bits, unsigned); the feeder does no arithmetic except under the macro.

## Timing
- Reset values (async, immediate on rst=1):
  - FSM=IDLE, FIFO empty, s_ready=1 after deassert.
  - mac_i=0, mac_j=0, mac_rst=0.
  - r_valid=0, r_data=0, r_ovf=0.
- Reset mid-vector: the partial vector and all buffered pairs are discarded; no result is produced.
- Latency: the last pair driven on mac_i/mac_j in cycle k gives CAPTURE in k+1 and r_valid=1 in k+2.
- First pair of a vector: pushed in cycle k into an empty FIFO while IDLE gives CLEAR at k+1 and first mac_i/mac_j drive at k+2.
- Throughput: a vector of N pairs with no underrun and r_ready=1 takes N+4 cycles (IDLE→IDLE).
- A single-pair vector (s_last on the first pair) is legal.

## Configuration
- MAC_FEEDER_OVF_EN defined:
  - A 12-bit shadow accumulator is cleared in CLEAR and adds mac_i*mac_j for each pair driven in STREAM.
  - r_ovf is registered in CAPTURE as (shadow > 511) and is valid with r_valid.
- Undefined: no shadow logic; r_ovf is constant 0.

## Test plan
- Push vector (9,10),(12,2),(9,2),(5,4)+last with r_ready=1 → r_data=152 and r_valid for exactly one cycle, 2 cycles after (5,4) is driven.
- Single pair (15,15)+last → r_data=225, r_ovf=0.
- Three pairs (15,15) → r_data=163 (675 mod 512); r_ovf=1 with the macro, 0 without.
- Hold r_ready=0 and push 2·DEPTH pairs of (1,1) with last on every 4th:
  - s_ready drops exactly when the FIFO holds DEPTH pairs.
  - r_data=4 is held stable until r_ready.
  - Every vector result is 4, in order.
- Push (3,3); gap of 5 cycles with s_valid=0; push (2,2)+last → r_data=13; mac_i=mac_j=0 during the gap.
- Assert rst while in STREAM after 2 of 4 pairs → all outputs at reset values immediately; a fresh vector (1,1)+last afterwards → r_data=1.
